// File: rtl/cdb_arbiter_pkg.sv
// Shared types and helpers for the common-data-bus arbiter of the Tomasulo core.
package cdb_arbiter_pkg;

  localparam int NUM_CDB_REQ = 4;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_TAG_W   = 3;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin successor of a granted index.
  function automatic int next_idx(input int g, input int n);
    return (g + 1) % n;
  endfunction

  localparam int CDB_SRC_W = idx_w(NUM_CDB_REQ);

  typedef logic [CDB_SRC_W-1:0] cdb_src_t;

  typedef struct packed {
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_TAG_W-1:0]  tag;
    logic                  valid;
  } cdb_req_t;

  typedef struct packed {
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_TAG_W-1:0]  tag;
    logic                  request;
  } cdb_data_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first held slot at or after rr_ptr wins.
module rr_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ,
  localparam int IDX_W  = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] held_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_o
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_i) + k) % NUM_REQ);
      if (!any_o && held_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with one holding slot per functional unit and a registered bus.
// Optional per-unit stall counters are built when CDB_ARB_STATS_EN is defined.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int TAG_W   = CDB_TAG_W,
  localparam int SRC_W  = idx_w(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           cdb_valid,
  output logic [DATA_W-1:0]              cdb_data,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic [SRC_W-1:0]               cdb_src
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]       stall_cnt
`endif
);

  logic [NUM_REQ-1:0]             held_q, held_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] slot_data_q;
  logic [NUM_REQ-1:0][TAG_W-1:0]  slot_tag_q;
  logic [SRC_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic                           cdb_valid_q;
  logic [DATA_W-1:0]              cdb_data_q;
  logic [TAG_W-1:0]               cdb_tag_q;
  logic [SRC_W-1:0]               cdb_src_q;

  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] accept;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .held_i      (held_q),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  // Ready depends only on state, rst and flush; a granted slot may refill in the same cycle.
  always_comb begin
    if (rst)        req_ready = '0;
    else if (flush) req_ready = '1;
    else            req_ready = ~held_q | grant;
  end

  assign accept = req_valid & req_ready & {NUM_REQ{~flush}};

  always_comb begin
    held_d   = (held_q & ~grant) | accept;
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = SRC_W'(next_idx(int'(grant_idx), NUM_REQ));
    if (flush) begin
      held_d   = '0;
      rr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      held_q   <= held_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Holding slots carry no reset; held_q alone qualifies their contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        slot_data_q[i] <= req_data[i];
        slot_tag_q[i]  <= req_tag[i];
      end
    end
  end

  // Bus payload holds its last value on idle cycles; only the valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_tag_q   <= '0;
      cdb_src_q   <= '0;
    end else if (flush || !grant_any) begin
      cdb_valid_q <= 1'b0;
    end else begin
      cdb_valid_q <= 1'b1;
      cdb_data_q  <= slot_data_q[grant_idx];
      cdb_tag_q   <= slot_tag_q[grant_idx];
      cdb_src_q   <= grant_idx;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_src   = cdb_src_q;

`ifdef CDB_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] stall_cnt_q;

  // Saturating per-unit stall counters; flush does not clear them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (held_q[i] && !grant[i] && !flush && stall_cnt_q[i] != 16'hFFFF)
          stall_cnt_q[i] <= stall_cnt_q[i] + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_cdb_arbiter;

  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0][31:0] req_data;
  logic [NR-1:0][2:0]  req_tag;
  logic [NR-1:0]     req_ready;
  logic              cdb_valid;
  logic [31:0]       cdb_data;
  logic [2:0]        cdb_tag;
  logic [1:0]        cdb_src;
`ifdef CDB_ARB_STATS_EN
  logic [NR-1:0][15:0] stall_cnt;
`endif

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_tag   (cdb_tag),
    .cdb_src   (cdb_src)
`ifdef CDB_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stamp 255 stands for the all-zero reset contents of the bus.
  function automatic logic [31:0] mkdata(input int s, input int i);
    if (s == 255) return 32'h0;
    return 32'h5A00_0000 | (32'(s) << 8) | 32'(i);
  endfunction

  function automatic logic [2:0] mktag(input int s, input int i);
    if (s == 255) return 3'd0;
    return 3'(s + i);
  endfunction

  typedef struct {
    logic       rst;
    logic       flush;
    logic [3:0] vld;
    logic [3:0] rdy;
    logic       cv;
    logic [1:0] src;
    int         stamp;
  } vec_t;

  vec_t tbl[28];

  task automatic drive_row(input int r);
    rst       = tbl[r].rst;
    flush     = tbl[r].flush;
    req_valid = tbl[r].vld;
    for (int i = 0; i < NR; i++) begin
      req_data[i] = mkdata(r, i);
      req_tag[i]  = mktag(r, i);
    end
  endtask

  // Each row: inputs for one cycle, ready during it, bus contents after its closing edge.
  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      drive_row(r);
      #1;
      chk($sformatf("row%0d_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_valid", r), 32'(cdb_valid), 32'(tbl[r].cv));
      chk($sformatf("row%0d_src", r), 32'(cdb_src), 32'(tbl[r].src));
      chk($sformatf("row%0d_data", r), cdb_data, mkdata(tbl[r].stamp, int'(tbl[r].src)));
      chk($sformatf("row%0d_tag", r), 32'(cdb_tag), 32'(mktag(tbl[r].stamp, int'(tbl[r].src))));
    end
  endtask

  // Scoreboard state for the stable-data back-pressure sequence.
  logic [31:0] sb_data[NR][$];
  logic [2:0]  sb_tag[NR][$];
  int          sent_k[NR];
  int          acc_cnt;
  int          rx_cnt;
  logic [NR-1:0] smp_v, smp_r;

  initial begin
    //            rst flush vld      rdy      cv src stamp
    tbl[0]  = '{1'b0, 1'b0, 4'b0001, 4'b1111, 1'b0, 2'd0, 255};
    tbl[1]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd0, 0};
    tbl[2]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0, 0};
    tbl[3]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 255};
    tbl[4]  = '{1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, 2'd0, 255};
    tbl[5]  = '{1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 4};
    tbl[6]  = '{1'b0, 1'b0, 4'b1111, 4'b0010, 1'b1, 2'd1, 4};
    tbl[7]  = '{1'b0, 1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 4};
    tbl[8]  = '{1'b0, 1'b0, 4'b1111, 4'b1000, 1'b1, 2'd3, 4};
    tbl[9]  = '{1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 5};
    tbl[10] = '{1'b0, 1'b0, 4'b1111, 4'b0010, 1'b1, 2'd1, 6};
    tbl[11] = '{1'b0, 1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 7};
    tbl[12] = '{1'b0, 1'b0, 4'b0000, 4'b1000, 1'b1, 2'd3, 8};
    tbl[13] = '{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 2'd3, 8};
    tbl[14] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd3, 8};
    tbl[15] = '{1'b0, 1'b0, 4'b1010, 4'b1111, 1'b0, 2'd3, 8};
    tbl[16] = '{1'b0, 1'b0, 4'b0000, 4'b0111, 1'b1, 2'd1, 15};
    tbl[17] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd3, 15};
    tbl[18] = '{1'b0, 1'b0, 4'b0100, 4'b1111, 1'b0, 2'd3, 15};
    tbl[19] = '{1'b0, 1'b0, 4'b1010, 4'b1111, 1'b1, 2'd2, 18};
    tbl[20] = '{1'b0, 1'b0, 4'b0000, 4'b1101, 1'b1, 2'd3, 19};
    tbl[21] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd1, 19};
    tbl[22] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd1, 19};
    tbl[23] = '{1'b0, 1'b0, 4'b1100, 4'b1111, 1'b0, 2'd1, 19};
    tbl[24] = '{1'b0, 1'b0, 4'b0100, 4'b0111, 1'b1, 2'd2, 23};
    tbl[25] = '{1'b0, 1'b0, 4'b0100, 4'b1011, 1'b1, 2'd3, 23};
    tbl[26] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd2, 24};
    tbl[27] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd2, 24};

    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_tag   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_valid", 32'(cdb_valid), 32'h0);
    chk("reset_data", cdb_data, 32'h0);
    chk("reset_tag_src", {27'd0, cdb_tag, cdb_src}, 32'h0);

    // Single request, reset, full contention, flush, pointer wrap, back-pressure.
    run_rows(0, 8);
`ifdef CDB_ARB_STATS_EN
    for (int i = 0; i < NR; i++)
      chk($sformatf("stall_cnt%0d_round1", i), 32'(stall_cnt[i]), 32'd3);
`endif
    run_rows(9, 27);

    // Stable-data producers with random gaps; every result must appear once, in per-unit order.
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    acc_cnt   = 0;
    rx_cnt    = 0;
    for (int i = 0; i < NR; i++) sent_k[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && sent_k[i] < 6 && $urandom_range(0, 3) != 0) begin
          req_valid[i] = 1'b1;
          req_data[i]  = 32'hB000_0000 | (32'(i) << 16) | 32'(sent_k[i]);
          req_tag[i]   = 3'(sent_k[i] + i);
        end
      end
      #3;
      smp_v = req_valid;
      smp_r = req_ready;
      @(posedge clk);
      #1;
      if (cdb_valid) begin
        rx_cnt++;
        if (sb_data[cdb_src].size() == 0) begin
          chk("sb_unexpected_src", 32'(cdb_src), 32'hFFFF_FFFF);
        end else begin
          chk("sb_data", cdb_data, sb_data[cdb_src].pop_front());
          chk("sb_tag", 32'(cdb_tag), 32'(sb_tag[cdb_src].pop_front()));
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (smp_v[i] && smp_r[i]) begin
          sb_data[i].push_back(req_data[i]);
          sb_tag[i].push_back(req_tag[i]);
          sent_k[i]++;
          acc_cnt++;
          req_valid[i] = 1'b0;
        end
      end
      if (acc_cnt == 4 * 6 && rx_cnt == 4 * 6) break;
    end
    chk("sb_accepted", 32'(acc_cnt), 32'd24);
    chk("sb_broadcast", 32'(rx_cnt), 32'd24);

    // Reset while all slots are held.
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      req_data[i] = 32'hC0DE_0000 | 32'(i);
      req_tag[i]  = 3'(i);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(cdb_valid), 32'h0);
    chk("midrst_data", cdb_data, 32'h0);
    chk("midrst_tag_src", {27'd0, cdb_tag, cdb_src}, 32'h0);
`ifdef CDB_ARB_STATS_EN
    for (int i = 0; i < NR; i++)
      chk($sformatf("midrst_stall%0d", i), 32'(stall_cnt[i]), 32'd0);
`endif
    rst          = 1'b0;
    req_valid    = 4'b0010;
    req_data[1]  = 32'h1234_5678;
    req_tag[1]   = 3'd6;
    #1;
    chk("postrst_ready", 32'(req_ready), 32'hF);
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("postrst_lat1_valid", 32'(cdb_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("postrst_lat2_valid", 32'(cdb_valid), 32'h1);
    chk("postrst_data", cdb_data, 32'h1234_5678);
    chk("postrst_tag", 32'(cdb_tag), 32'd6);
    chk("postrst_src", 32'(cdb_src), 32'd1);
    @(posedge clk);
    #1;
    chk("postrst_pulse_end", 32'(cdb_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
